rom_burst_reader: RTL and testbench
===================================

ROM_BURST_READER -- requirements
Module: rom_burst_reader

Interface
REQ-001 W_DATA, 8, ROM data word width.
REQ-002 W_ADDR, 12, ROM address width; also the burst-length width.
REQ-003 MAX_OUTSTANDING, 2, maximum in-flight ROM reads (address accepted, data not yet accepted); legal range 1..15.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start_valid / start_ready  in / out  1 / 1  burst-command handshake.
REQ-007 start_addr  in  W_ADDR  first ROM word address.
REQ-008 start_len  in  W_ADDR  number of words in the burst; 0 is legal.
REQ-009 addr1_valid / addr1_ready  out / in  1 / 1  ROM address-request handshake.
REQ-010 addr1_data  out  W_ADDR  ROM address.
REQ-011 data1_valid / data1_ready  in / out  1 / 1  ROM read-data handshake.
REQ-012 data1  in  W_DATA  ROM read data, returned in request order.
REQ-013 out_valid / out_ready  out / in  1 / 1  output data-stream handshake.
REQ-014 out_data  out  W_DATA  output word.
REQ-015 out_last  out  1  marks the final word of a burst.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  single-cycle pulse at burst completion.

Function
REQ-018 A transfer occurs on any interface in a cycle where its valid and ready are both high; valid, once raised, is held with stable payload until the transfer.
REQ-019 FSM states are IDLE, RUN and DONE; start_ready is high only in IDLE.
REQ-020 IDLE to RUN on a start transfer with start_len != 0: latch next address = start_addr, remaining issue count = start_len, remaining receive count = start_len.
REQ-021 IDLE to DONE on a start transfer with start_len == 0; no address or output transfer occurs.
REQ-022 In RUN, addr1_valid = (remaining issue count != 0) AND (outstanding < MAX_OUTSTANDING); addr1_data = next address.
REQ-023 On each address transfer, next address increments by 1 modulo 2^W_ADDR (0xFFF wraps to 0x000), and remaining issue count decrements.
REQ-024 The outstanding counter increments on an address transfer and decrements on a data1 transfer; both in the same cycle leave it unchanged.
REQ-025 Each data1 transfer delivers exactly one output word, in order, and decrements remaining receive count.
REQ-026 out_last is high on the output word for which remaining receive count was 1 at its data1 transfer.
REQ-027 RUN to DONE on the cycle after the output transfer carrying out_last; DONE lasts one cycle with done = 1, then IDLE.
REQ-028 data1_valid outside RUN is a protocol error; it is ignored and data1_ready is 0.
REQ-029 Address issue rate is one per cycle when addr1_ready and credits permit; back-pressure on out_ready stalls data1_ready but does not block address issue until credits are exhausted.

Reset
REQ-030 Asserting rst at any time, including mid-burst, immediately forces IDLE, clears counters, next address, and any buffered data, and drives start_ready = 0, addr1_valid = 0, data1_ready = 0, out_valid = 0, out_last = 0, busy = 0, done = 0, out_data = 0, addr1_data = 0 while rst is high.
REQ-031 start_ready rises in the first clock cycle after rst deasserts.

Configuration
REQ-032 With ROM_READER_SKID_EN defined, the output passes through a 2-entry registered skid buffer; data1_ready = (buffer not full) in RUN; out_valid, out_data and out_last are register outputs; 1 cycle latency from data1 transfer to out_valid.
REQ-033 Without ROM_READER_SKID_EN, the path is combinational: out_valid = data1_valid in RUN, out_data = data1, data1_ready = out_ready in RUN; 0 cycle latency.
REQ-034 In both builds, words, order, out_last and done timing relative to the last output transfer are identical.

Verification
REQ-035 start_addr=0x010, len=4, addr1_ready=1, one-cycle ROM, out_ready=1 -> addresses 0x010..0x013 on consecutive cycles, 4 outputs, out_last on the 4th, done 1 cycle later.
REQ-036 start_addr=0xFFE, len=3 -> addresses 0xFFE, 0xFFF, 0x000 in order.
REQ-037 len=0 -> no addr1_valid, busy high 1 cycle, done pulses in the cycle after the start transfer, start_ready returns next cycle.
REQ-038 len=8, out_ready=0 for 10 cycles -> at most MAX_OUTSTANDING=2 address transfers (plus 2 in skid build) until out_ready rises; all 8 words then delivered in order.
REQ-039 rst asserted after 3 of 6 words delivered -> all outputs reset values in the same cycle; new burst start_addr=0x100, len=2 after release completes normally.
REQ-040 Random addr1_ready / data1_valid / out_ready stalls, 1000 bursts, both macro settings -> output sequence equals ROM contents at the addresses issued; outstanding never exceeds MAX_OUTSTANDING.

Source files
------------

// File: rtl/rom_burst_reader.sv
// rom_burst_reader: reads a burst of consecutive ROM words and streams them out.
// A start command (address, length) launches address requests to the ROM with
// up to MAX_OUTSTANDING reads in flight; returned words are forwarded in order
// on the output stream, the final word flagged with out_last.
// Optional build macro ROM_READER_SKID_EN: registers the output path through a
// 2-entry skid buffer instead of the default combinational pass-through.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for a start command, start_ready high
// RUN     | issuing addresses and forwarding returned words
// DONE    | one-cycle completion pulse on done, then back to IDLE
module rom_burst_reader #(
  parameter int W_DATA          = 8,
  parameter int W_ADDR          = 12,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [W_ADDR-1:0] start_addr,
  input  logic [W_ADDR-1:0] start_len,
  output logic              addr1_valid,
  input  logic              addr1_ready,
  output logic [W_ADDR-1:0] addr1_data,
  input  logic              data1_valid,
  output logic              data1_ready,
  input  logic [W_DATA-1:0] data1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_DATA-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  // Four bits covers the full legal credit range of 1..15.
  localparam int W_OUTST = 4;
  localparam logic [W_OUTST-1:0] MAX_OUTST = W_OUTST'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [W_ADDR-1:0]   next_addr_q, next_addr_d;
  logic [W_ADDR-1:0]   issue_cnt_q, issue_cnt_d;
  logic [W_ADDR-1:0]   recv_cnt_q, recv_cnt_d;
  logic [W_OUTST-1:0]  outst_q, outst_d;
  logic                start_ready_q, start_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic run;
  logic start_xfer;
  logic addr_xfer;
  logic d1_xfer;
  logic out_xfer;
  logic recv_last;

  assign run         = (state_q == ST_RUN);
  assign start_xfer  = start_valid & start_ready_q;
  assign addr1_valid = run & (issue_cnt_q != '0) & (outst_q < MAX_OUTST);
  assign addr1_data  = next_addr_q;
  assign addr_xfer   = addr1_valid & addr1_ready;
  assign d1_xfer     = data1_valid & data1_ready;
  assign out_xfer    = out_valid & out_ready;
  // The word accepted while one word remains is the last of the burst.
  assign recv_last   = (recv_cnt_q == W_ADDR'(1));

  assign start_ready = start_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef ROM_READER_SKID_EN
  // Entry 0 is the head and drives the output directly from its registers.
  logic              sk0_vld_q, sk0_vld_d;
  logic [W_DATA-1:0] sk0_data_q, sk0_data_d;
  logic              sk0_last_q, sk0_last_d;
  logic              sk1_vld_q, sk1_vld_d;
  logic [W_DATA-1:0] sk1_data_q, sk1_data_d;
  logic              sk1_last_q, sk1_last_d;

  assign data1_ready = run & ~sk1_vld_q;
  assign out_valid   = sk0_vld_q;
  assign out_data    = sk0_data_q;
  assign out_last    = sk0_last_q;

  // Skid buffer: pop shifts entry 1 into the head, push fills the first free slot.
  always_comb begin
    sk0_vld_d  = sk0_vld_q;
    sk0_data_d = sk0_data_q;
    sk0_last_d = sk0_last_q;
    sk1_vld_d  = sk1_vld_q;
    sk1_data_d = sk1_data_q;
    sk1_last_d = sk1_last_q;
    if (out_xfer) begin
      sk0_vld_d  = sk1_vld_q;
      sk0_data_d = sk1_data_q;
      sk0_last_d = sk1_last_q;
      sk1_vld_d  = 1'b0;
    end
    if (d1_xfer) begin
      if (!sk0_vld_d) begin
        sk0_vld_d  = 1'b1;
        sk0_data_d = data1;
        sk0_last_d = recv_last;
      end else begin
        sk1_vld_d  = 1'b1;
        sk1_data_d = data1;
        sk1_last_d = recv_last;
      end
    end
  end

  // Skid buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sk0_vld_q  <= 1'b0;
      sk0_data_q <= '0;
      sk0_last_q <= 1'b0;
      sk1_vld_q  <= 1'b0;
      sk1_data_q <= '0;
      sk1_last_q <= 1'b0;
    end else begin
      sk0_vld_q  <= sk0_vld_d;
      sk0_data_q <= sk0_data_d;
      sk0_last_q <= sk0_last_d;
      sk1_vld_q  <= sk1_vld_d;
      sk1_data_q <= sk1_data_d;
      sk1_last_q <= sk1_last_d;
    end
  end
`else
  // Pass-through: ROM data goes straight to the output while bursting.
  assign data1_ready = run & out_ready;
  assign out_valid   = run & data1_valid;
  assign out_data    = run ? data1 : '0;
  assign out_last    = run & data1_valid & recv_last;
`endif

  // Next-state, burst counters and credit tracking.
  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    outst_d     = outst_q;
    case (state_q)
      ST_IDLE: begin
        if (start_xfer) begin
          next_addr_d = start_addr;
          issue_cnt_d = start_len;
          recv_cnt_d  = start_len;
          outst_d     = '0;
          state_d     = (start_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (addr_xfer) begin
          next_addr_d = next_addr_q + W_ADDR'(1);
          issue_cnt_d = issue_cnt_q - W_ADDR'(1);
        end
        if (d1_xfer) begin
          recv_cnt_d = recv_cnt_q - W_ADDR'(1);
        end
        case ({addr_xfer, d1_xfer})
          2'b10:   outst_d = outst_q + W_OUTST'(1);
          2'b01:   outst_d = outst_q - W_OUTST'(1);
          default: outst_d = outst_q;
        endcase
        if (out_xfer && out_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Status outputs are registered copies of the upcoming state.
    start_ready_d = (state_d == ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_DONE);
  end

  // State and counter registers; start_ready stays low until the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      next_addr_q   <= '0;
      issue_cnt_q   <= '0;
      recv_cnt_q    <= '0;
      outst_q       <= '0;
      start_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      next_addr_q   <= next_addr_d;
      issue_cnt_q   <= issue_cnt_d;
      recv_cnt_q    <= recv_cnt_d;
      outst_q       <= outst_d;
      start_ready_q <= start_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: a ROM responder with random stalls feeds the DUT,
// observed address/output streams are checked against a burst-level model
// (address a+i mod 4096, data rom[a+i], last on word len-1).
module tb_rom_burst_reader;

  localparam int W_DATA = 8;
  localparam int W_ADDR = 12;
  localparam int MAXO   = 2;
`ifdef ROM_READER_SKID_EN
  localparam int SKID = 2;
`else
  localparam int SKID = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_valid = 1'b0;
  logic              start_ready;
  logic [W_ADDR-1:0] start_addr = '0;
  logic [W_ADDR-1:0] start_len = '0;
  logic              addr1_valid;
  logic              addr1_ready = 1'b0;
  logic [W_ADDR-1:0] addr1_data;
  logic              data1_valid = 1'b0;
  logic              data1_ready;
  logic [W_DATA-1:0] data1 = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [W_DATA-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  rom_burst_reader #(.W_DATA(W_DATA), .W_ADDR(W_ADDR), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_addr(start_addr), .start_len(start_len),
    .addr1_valid(addr1_valid), .addr1_ready(addr1_ready), .addr1_data(addr1_data),
    .data1_valid(data1_valid), .data1_ready(data1_ready), .data1(data1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [W_DATA-1:0] rom [0:4095];
  logic [W_ADDR-1:0] rom_q[$];
  logic [W_ADDR-1:0] iss_q[$];
  int                iss_cyc_q[$];
  logic [W_DATA-1:0] out_q[$];
  logic              last_q[$];
  int cyc = 0;
  int outst = 0;
  int max_outst = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_out_cyc = -1;
  int busy_cnt = 0;
  int p_addr = 100, p_d1 = 100, p_out = 100;
  bit force_stall = 0;
  bit force_d1 = 0;
  bit d1_hold = 0;

  // ROM responder and bus monitor: drive at the falling edge, observe 1 ns later.
  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = W_DATA'($urandom);
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        rom_q.delete();
        d1_hold = 0;
        data1_valid = 1'b0;
        data1 = '0;
        outst = 0;
        addr1_ready = 1'b0;
        out_ready = 1'b0;
      end else begin
        addr1_ready = ($urandom_range(0, 99) < p_addr);
        out_ready = !force_stall && ($urandom_range(0, 99) < p_out);
        if (!d1_hold) begin
          if (force_d1) begin
            data1_valid = 1'b1;
            data1 = 8'hA5;
          end else if (rom_q.size() > 0 && $urandom_range(0, 99) < p_d1) begin
            data1_valid = 1'b1;
            data1 = rom[rom_q[0]];
          end else begin
            data1_valid = 1'b0;
            data1 = '0;
          end
        end
        #1;
        if (addr1_valid && addr1_ready) begin
          rom_q.push_back(addr1_data);
          iss_q.push_back(addr1_data);
          iss_cyc_q.push_back(cyc);
          outst++;
        end
        if (data1_valid && data1_ready) begin
          if (rom_q.size() > 0) void'(rom_q.pop_front());
          outst--;
          d1_hold = 0;
        end else begin
          d1_hold = data1_valid && !force_d1;
        end
        if (outst > max_outst) max_outst = outst;
        if (out_valid && out_ready) begin
          out_q.push_back(out_data);
          last_q.push_back(out_last);
          if (out_last) last_out_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (busy) busy_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    n_chk++;
    if ({start_ready, addr1_valid, data1_ready, out_valid, out_last, busy, done} !== 7'b0)
      $display("FAIL reset_ctrl: got %b want 0000000",
               {start_ready, addr1_valid, data1_ready, out_valid, out_last, busy, done});
    else n_pass++;
    n_chk++;
    if (addr1_data !== '0) $display("FAIL reset_addr: got %h want 000", addr1_data);
    else n_pass++;
    n_chk++;
    if (out_data !== '0) $display("FAIL reset_data: got %h want 00", out_data);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #2;
    n_chk++;
    if (start_ready !== 1'b0) $display("FAIL rel_start_ready_early: got %b want 0", start_ready);
    else n_pass++;
    @(negedge clk);
    #2;
    n_chk++;
    if (start_ready !== 1'b1) $display("FAIL rel_start_ready: got %b want 1", start_ready);
    else n_pass++;
  endtask

  task automatic test_idle_protocol();
    force_d1 = 1;
    repeat (3) @(negedge clk);
    #2;
    n_chk++;
    if ({data1_ready, out_valid, busy} !== 3'b000)
      $display("FAIL idle_d1: got rdy/oval/busy=%b want 000", {data1_ready, out_valid, busy});
    else n_pass++;
    force_d1 = 0;
    @(negedge clk);
  endtask

  // One burst: start, optional output stall window, wait for done, compare to model.
  task automatic test_burst(input logic [W_ADDR-1:0] a, input logic [W_ADDR-1:0] n,
                            input int stall, input bit consec, input string tag);
    int d0, s_cyc, budget;
    bit ok;
    logic [W_ADDR-1:0] ea;
    @(negedge clk);
    iss_q.delete(); iss_cyc_q.delete(); out_q.delete(); last_q.delete();
    busy_cnt = 0; done_cyc = -1; last_out_cyc = -1;
    d0 = done_cnt;
    s_cyc = -1;
    force_stall = (stall > 0);
    start_valid = 1'b1; start_addr = a; start_len = n;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      #2;
      if (start_ready) begin ok = 1; s_cyc = cyc; break; end
      @(negedge clk);
    end
    n_chk++;
    if (!ok) $display("FAIL %s start_accept: got no start_ready want accept", tag);
    else n_pass++;
    @(negedge clk);
    start_valid = 1'b0;
    if (stall > 0) begin
      repeat (stall - 1) @(negedge clk);
      #2;
      n_chk++;
      if (iss_q.size() > MAXO + SKID)
        $display("FAIL %s stall_issue: got %0d addresses want <= %0d", tag, iss_q.size(), MAXO + SKID);
      else n_pass++;
      n_chk++;
      if (out_q.size() != 0) $display("FAIL %s stall_out: got %0d words want 0", tag, out_q.size());
      else n_pass++;
      force_stall = 0;
    end
    budget = 100 + 40 * int'(n);
    for (int k = 0; k < budget && done_cnt == d0; k++) begin
      @(negedge clk);
      #2;
    end
    n_chk++;
    if (done_cnt != d0 + 1) $display("FAIL %s done_seen: got %0d pulses want 1", tag, done_cnt - d0);
    else n_pass++;
    n_chk++;
    if (iss_q.size() != int'(n)) $display("FAIL %s addr_count: got %0d want %0d", tag, iss_q.size(), n);
    else n_pass++;
    for (int i = 0; i < iss_q.size() && i < int'(n); i++) begin
      ea = a + W_ADDR'(i);
      n_chk++;
      if (iss_q[i] !== ea) $display("FAIL %s addr[%0d]: got %h want %h", tag, i, iss_q[i], ea);
      else n_pass++;
      if (consec) begin
        n_chk++;
        if (iss_cyc_q[i] != s_cyc + 1 + i)
          $display("FAIL %s addr_cyc[%0d]: got %0d want %0d", tag, i, iss_cyc_q[i], s_cyc + 1 + i);
        else n_pass++;
      end
    end
    n_chk++;
    if (out_q.size() != int'(n)) $display("FAIL %s out_count: got %0d want %0d", tag, out_q.size(), n);
    else n_pass++;
    for (int i = 0; i < out_q.size() && i < int'(n); i++) begin
      ea = a + W_ADDR'(i);
      n_chk++;
      if (out_q[i] !== rom[ea]) $display("FAIL %s data[%0d]: got %h want %h", tag, i, out_q[i], rom[ea]);
      else n_pass++;
      n_chk++;
      if (last_q[i] !== (i == int'(n) - 1))
        $display("FAIL %s last[%0d]: got %b want %b", tag, i, last_q[i], (i == int'(n) - 1));
      else n_pass++;
    end
    n_chk++;
    if (n == 0) begin
      if (done_cyc != s_cyc + 1) $display("FAIL %s done_time: got %0d want %0d", tag, done_cyc, s_cyc + 1);
      else n_pass++;
    end else begin
      if (done_cyc != last_out_cyc + 1)
        $display("FAIL %s done_time: got %0d want %0d", tag, done_cyc, last_out_cyc + 1);
      else n_pass++;
    end
    n_chk++;
    if (busy_cnt != done_cyc - s_cyc)
      $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_cnt, done_cyc - s_cyc);
    else n_pass++;
    n_chk++;
    if (max_outst > MAXO) $display("FAIL %s outstanding: got %0d want <= %0d", tag, max_outst, MAXO);
    else n_pass++;
    @(negedge clk);
    #2;
    n_chk++;
    if ({start_ready, busy} !== 2'b10) $display("FAIL %s back_idle: got sr/busy=%b want 10", tag, {start_ready, busy});
    else n_pass++;
  endtask

  task automatic test_basic();
    p_addr = 100; p_d1 = 100; p_out = 100;
    test_burst(12'h010, 12'd4, 0, 1, "basic");
  endtask

  task automatic test_wrap();
    test_burst(12'hFFE, 12'd3, 0, 0, "wrap");
  endtask

  task automatic test_len0();
    test_burst(12'h555, 12'd0, 0, 0, "len0");
  endtask

  task automatic test_backpressure();
    test_burst(12'h2F0, 12'd8, 10, 0, "backpressure");
  endtask

  task automatic test_reset_mid();
    bit ok;
    p_addr = 100; p_d1 = 100; p_out = 100;
    @(negedge clk);
    out_q.delete();
    start_valid = 1'b1; start_addr = 12'h3A0; start_len = 12'd6;
    @(negedge clk);
    #2;
    start_valid = 1'b0;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      if (out_q.size() >= 3) begin ok = 1; break; end
      @(negedge clk);
      #2;
    end
    n_chk++;
    if (!ok) $display("FAIL midrst_progress: got %0d words want 3", out_q.size());
    else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({start_ready, addr1_valid, data1_ready, out_valid, out_last, busy, done} !== 7'b0)
      $display("FAIL midrst_ctrl: got %b want 0000000",
               {start_ready, addr1_valid, data1_ready, out_valid, out_last, busy, done});
    else n_pass++;
    n_chk++;
    if ({addr1_data, out_data} !== '0) $display("FAIL midrst_bus: got %h/%h want 0/0", addr1_data, out_data);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_burst(12'h100, 12'd2, 0, 0, "after_reset");
  endtask

  task automatic test_random();
    logic [W_ADDR-1:0] a, n;
    for (int b = 0; b < 1000; b++) begin
      p_addr = $urandom_range(50, 100);
      p_d1   = $urandom_range(50, 100);
      p_out  = $urandom_range(50, 100);
      a = W_ADDR'($urandom_range(0, 4095));
      n = W_ADDR'($urandom_range(0, 8));
      test_burst(a, n, 0, 0, "random");
    end
    p_addr = 100; p_d1 = 100; p_out = 100;
  endtask

  initial begin
    test_reset();
    test_idle_protocol();
    test_basic();
    test_wrap();
    test_len0();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
